xspi_cmd_arbiter: RTL and testbench
===================================

# xspi_cmd_arbiter

Memory-clock-domain command arbiter between the AHB command path and the special-instruction requester, sharing the single XSPI memory-controller command port. Grants one requester at a time with round-robin tie-break, holds the command on the controller handshake, then waits for transaction completion with a watchdog. While a special instruction is in flight, it asserts the stall toward the AHB slave.

## Interface
- LEN_WIDTH, 10: transfer length width.
- TO_WIDTH, 12: watchdog counter width.
- TIMEOUT, 4095: BUSY cycles allowed before abort; must fit TO_WIDTH.
- mem_clk  in  1  memory-side clock; all logic on rising edge.
- mem_rst  in  1  synchronous, active-high reset.
- ahb_cmd_valid  in  1  AHB command pending.
- ahb_cmd_ready  out  1  AHB command accepted this cycle.
- ahb_addr  in  32  AHB command address.
- ahb_write  in  1  1 = write.
- ahb_len  in  LEN_WIDTH  AHB beat count.
- ahb_size  in  3  AHB beat size.
- spl_instr_req  in  1  special instruction request; level, held until ack.
- spl_instr_opcode  in  8  special instruction opcode.
- spl_instr_addr  in  32  special instruction address.
- spl_instr_write  in  1  special instruction direction.
- spl_instr_len  in  LEN_WIDTH  special instruction byte count.
- spl_instr_ack  out  1  one-cycle completion pulse.
- spl_instr_stall  out  1  AHB-side stall while special instruction owns the port.
- mc_cmd_valid  out  1  command to memory controller.
- mc_cmd_ready  in  1  controller accepts command.
- mc_cmd_addr  out  32  issued address.
- mc_cmd_write  out  1  issued direction.
- mc_cmd_len  out  LEN_WIDTH  issued length.
- mc_cmd_size  out  3  issued size; 3'b000 for special instructions.
- mc_cmd_spl  out  1  1 = special instruction.
- mc_cmd_opcode  out  8  opcode; 8'h00 for AHB commands.
- mc_xfer_done  in  1  one-cycle pulse; the transaction has completed and CE is released.
- err_clr  in  1  clears xfer_timeout.
- xfer_timeout  out  1  sticky watchdog error.

## Operation
- States: IDLE, ISSUE, BUSY, DONE. State and every output reset to IDLE / 0. The last_grant register resets to SPL, so AHB wins the first tie.
- IDLE, selection:
  - Only one requester pending: select it.
  - Both pending: select the one not equal to last_grant.
- IDLE, grant:
  - AHB selected: ahb_cmd_ready=1, combinational, this cycle only.
  - Payload is captured into the mc_cmd_* registers at the edge.
  - last_grant and the grant owner are updated.
  - Next state is ISSUE.
- ISSUE: mc_cmd_valid=1 with stable payload until mc_cmd_ready=1; next state is BUSY at that edge.
- BUSY: watchdog counts from 0.
  - mc_xfer_done=1: go to DONE.
  - Count reaches TIMEOUT-1 without done: set xfer_timeout, go to DONE (abort).
- DONE: one cycle. If the owner is SPL, spl_instr_ack=1. Next state is IDLE.
- spl_instr_stall is 1 from the edge that grants SPL through the edge leaving DONE. It is never asserted for AHB grants.
- xfer_timeout is sticky until err_clr. If err_clr and a new timeout occur in the same cycle, set wins.
- mc_cmd_* payload holds its last value outside ISSUE. Consumers qualify it with mc_cmd_valid only.

## Timing
- Request in IDLE at cycle N leads to mc_cmd_valid at N+1.
- Minimum occupancy, request to next IDLE, is 4 cycles: IDLE, ISSUE with ready, BUSY with done, DONE.
- The DONE bubble guarantees that a requester dropping req on the edge after ack is not re-granted.
- mc_xfer_done is ignored outside BUSY. This includes a done in the same cycle as mc_cmd_ready in ISSUE.
- mc_xfer_done in the same cycle as watchdog terminal count: done wins, no error.
- ahb_cmd_valid dropped while in IDLE without ready: no grant, no state change.
- Reset mid-transaction:
  - All state and outputs return to 0/IDLE next edge; the in-flight command is discarded.
  - No ack is issued; the SPL requester re-requests.

## Structure
- Package xspi_arb_pkg:
  - State enum: IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, DONE=2'd3.
  - Grant constants: GRANT_AHB=1'b0, GRANT_SPL=1'b1.
  - SPL_SIZE=3'b000.
  - AHB_OPCODE=8'h00.
- Sub-module xspi_arb_wdog:
  - Ports: clear, enable, terminal-count output.
  - TO_WIDTH counter compared against TIMEOUT-1.
  - Instantiated once; cleared on entry to BUSY.

## Test plan
- AHB only:
  - Stimulus: ahb_addr=32'h0000_1000, len=16, write=1; mc_cmd_ready=1 immediately; done 5 cycles later.
  - Response: ready pulse at N, mc_cmd_valid at N+1 with the same payload, back to IDLE at done+2, spl_instr_ack never asserted.
- Simultaneous requests from reset:
  - Response: AHB granted first; SPL next with opcode 8'h05 and mc_cmd_spl=1.
  - spl_instr_stall high through DONE; spl_instr_ack is one cycle.
- Back-to-back contention:
  - Stimulus: both requesters held high for 4 transactions.
  - Response: grants alternate AHB, SPL, AHB, SPL.
- Backpressure:
  - Stimulus: mc_cmd_ready low for 7 cycles.
  - Response: mc_cmd_valid and payload stable all 7 cycles; mc_xfer_done pulses injected during ISSUE are ignored.
- Watchdog (TIMEOUT=16):
  - Stimulus: no done.
  - Response: xfer_timeout set after 16 BUSY cycles, then DONE and IDLE.
  - Variant: done on the terminal cycle gives no error.
  - err_clr clears xfer_timeout.
- Reset mid-BUSY during an SPL transaction:
  - Response: next edge all outputs 0 and stall 0, no ack.
  - A later request is granted normally.

Source files
------------

// File: rtl/xspi_arb_pkg.sv
// Shared types and constants for the XSPI command arbiter.
// Grant encoding doubles as the last_grant / owner register value.
package xspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic       GRANT_AHB  = 1'b0;
  localparam logic       GRANT_SPL  = 1'b1;
  localparam logic [2:0] SPL_SIZE   = 3'b000;
  localparam logic [7:0] AHB_OPCODE = 8'h00;

  // Round-robin pick; only meaningful when at least one requester is pending.
  function automatic logic pick_grant(input logic ahb_v, input logic spl_v, input logic last);
    if (ahb_v && spl_v) begin
      return ~last;
    end else if (spl_v) begin
      return GRANT_SPL;
    end else begin
      return GRANT_AHB;
    end
  endfunction

endpackage

// File: rtl/xspi_arb_wdog.sv
// BUSY-phase watchdog: up-counter from zero, terminal count at TIMEOUT-1.
// Counter holds at terminal count until the next clear.
module xspi_arb_wdog #(
  parameter int TO_WIDTH = 12,
  parameter int TIMEOUT  = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TO_WIDTH-1:0] TC_VAL = TO_WIDTH'(TIMEOUT - 1);

  logic [TO_WIDTH-1:0] cnt_q;
  logic [TO_WIDTH-1:0] cnt_d;

  assign tc = enable && (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xspi_cmd_arbiter.sv
// Arbitrates the AHB command path and the special-instruction requester
// onto the single XSPI memory-controller command port.
//
// state | meaning
// IDLE  | pick a requester (round-robin on tie), capture payload
// ISSUE | mc_cmd_valid held until the controller takes the command
// BUSY  | wait for mc_xfer_done, watchdog running
// DONE  | one-cycle bubble; ack pulse when the owner is SPL
module xspi_cmd_arbiter
  import xspi_arb_pkg::*;
#(
  parameter int LEN_WIDTH = 10,
  parameter int TO_WIDTH  = 12,
  parameter int TIMEOUT   = 4095
) (
  input  logic                 mem_clk,
  input  logic                 mem_rst,
  input  logic                 ahb_cmd_valid,
  output logic                 ahb_cmd_ready,
  input  logic [31:0]          ahb_addr,
  input  logic                 ahb_write,
  input  logic [LEN_WIDTH-1:0] ahb_len,
  input  logic [2:0]           ahb_size,
  input  logic                 spl_instr_req,
  input  logic [7:0]           spl_instr_opcode,
  input  logic [31:0]          spl_instr_addr,
  input  logic                 spl_instr_write,
  input  logic [LEN_WIDTH-1:0] spl_instr_len,
  output logic                 spl_instr_ack,
  output logic                 spl_instr_stall,
  output logic                 mc_cmd_valid,
  input  logic                 mc_cmd_ready,
  output logic [31:0]          mc_cmd_addr,
  output logic                 mc_cmd_write,
  output logic [LEN_WIDTH-1:0] mc_cmd_len,
  output logic [2:0]           mc_cmd_size,
  output logic                 mc_cmd_spl,
  output logic [7:0]           mc_cmd_opcode,
  input  logic                 mc_xfer_done,
  input  logic                 err_clr,
  output logic                 xfer_timeout
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic       timeout_q, timeout_d;

  logic [31:0]          addr_q, addr_d;
  logic                 write_q, write_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic                 spl_q, spl_d;
  logic [7:0]           opcode_q, opcode_d;

  logic any_req;
  logic sel;
  logic timeout_set;
  logic wdog_clr;
  logic wdog_en;
  logic wdog_tc;

  assign any_req = ahb_cmd_valid | spl_instr_req;
  assign sel     = pick_grant(ahb_cmd_valid, spl_instr_req, last_grant_q);

  xspi_arb_wdog #(
    .TO_WIDTH (TO_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) u_wdog (
    .clk    (mem_clk),
    .rst    (mem_rst),
    .clear  (wdog_clr),
    .enable (wdog_en),
    .tc     (wdog_tc)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    write_d       = write_q;
    len_d         = len_q;
    size_d        = size_q;
    spl_d         = spl_q;
    opcode_d      = opcode_q;
    ahb_cmd_ready = 1'b0;
    wdog_clr      = 1'b0;
    wdog_en       = 1'b0;
    timeout_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ISSUE;
          owner_d      = sel;
          last_grant_d = sel;
          if (sel == GRANT_AHB) begin
            ahb_cmd_ready = 1'b1;
            addr_d        = ahb_addr;
            write_d       = ahb_write;
            len_d         = ahb_len;
            size_d        = ahb_size;
            spl_d         = 1'b0;
            opcode_d      = AHB_OPCODE;
          end else begin
            addr_d   = spl_instr_addr;
            write_d  = spl_instr_write;
            len_d    = spl_instr_len;
            size_d   = SPL_SIZE;
            spl_d    = 1'b1;
            opcode_d = spl_instr_opcode;
          end
        end
      end
      ISSUE: begin
        // A done pulse coincident with ready belongs to nothing we issued.
        if (mc_cmd_ready) begin
          state_d  = BUSY;
          wdog_clr = 1'b1;
        end
      end
      BUSY: begin
        wdog_en = 1'b1;
        if (mc_xfer_done) begin
          state_d = DONE;
        end else if (wdog_tc) begin
          state_d     = DONE;
          timeout_set = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    timeout_d = timeout_q;
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (err_clr) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_SPL;
      owner_q      <= GRANT_AHB;
      timeout_q    <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      spl_q        <= 1'b0;
      opcode_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      timeout_q    <= timeout_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      len_q        <= len_d;
      size_q       <= size_d;
      spl_q        <= spl_d;
      opcode_q     <= opcode_d;
    end
  end

  assign mc_cmd_valid    = (state_q == ISSUE);
  assign spl_instr_ack   = (state_q == DONE) && (owner_q == GRANT_SPL);
  assign spl_instr_stall = (state_q != IDLE) && (owner_q == GRANT_SPL);
  assign mc_cmd_addr     = addr_q;
  assign mc_cmd_write    = write_q;
  assign mc_cmd_len      = len_q;
  assign mc_cmd_size     = size_q;
  assign mc_cmd_spl      = spl_q;
  assign mc_cmd_opcode   = opcode_q;
  assign xfer_timeout    = timeout_q;

endmodule

// File: tb/tb_xspi_cmd_arbiter.sv
// Self-checking bench for xspi_cmd_arbiter; issued commands are checked
// against a queue of expected commands built from the driven stimulus.
module tb_xspi_cmd_arbiter;

  localparam int LW = 10;
  localparam int TW = 12;
  localparam int TO = 16;

  logic          mem_clk = 1'b0;
  logic          mem_rst;
  logic          ahb_cmd_valid;
  logic          ahb_cmd_ready;
  logic [31:0]   ahb_addr;
  logic          ahb_write;
  logic [LW-1:0] ahb_len;
  logic [2:0]    ahb_size;
  logic          spl_instr_req;
  logic [7:0]    spl_instr_opcode;
  logic [31:0]   spl_instr_addr;
  logic          spl_instr_write;
  logic [LW-1:0] spl_instr_len;
  logic          spl_instr_ack;
  logic          spl_instr_stall;
  logic          mc_cmd_valid;
  logic          mc_cmd_ready;
  logic [31:0]   mc_cmd_addr;
  logic          mc_cmd_write;
  logic [LW-1:0] mc_cmd_len;
  logic [2:0]    mc_cmd_size;
  logic          mc_cmd_spl;
  logic [7:0]    mc_cmd_opcode;
  logic          mc_xfer_done;
  logic          err_clr;
  logic          xfer_timeout;

  xspi_cmd_arbiter #(.LEN_WIDTH(LW), .TO_WIDTH(TW), .TIMEOUT(TO)) dut (
    .mem_clk          (mem_clk),
    .mem_rst          (mem_rst),
    .ahb_cmd_valid    (ahb_cmd_valid),
    .ahb_cmd_ready    (ahb_cmd_ready),
    .ahb_addr         (ahb_addr),
    .ahb_write        (ahb_write),
    .ahb_len          (ahb_len),
    .ahb_size         (ahb_size),
    .spl_instr_req    (spl_instr_req),
    .spl_instr_opcode (spl_instr_opcode),
    .spl_instr_addr   (spl_instr_addr),
    .spl_instr_write  (spl_instr_write),
    .spl_instr_len    (spl_instr_len),
    .spl_instr_ack    (spl_instr_ack),
    .spl_instr_stall  (spl_instr_stall),
    .mc_cmd_valid     (mc_cmd_valid),
    .mc_cmd_ready     (mc_cmd_ready),
    .mc_cmd_addr      (mc_cmd_addr),
    .mc_cmd_write     (mc_cmd_write),
    .mc_cmd_len       (mc_cmd_len),
    .mc_cmd_size      (mc_cmd_size),
    .mc_cmd_spl       (mc_cmd_spl),
    .mc_cmd_opcode    (mc_cmd_opcode),
    .mc_xfer_done     (mc_xfer_done),
    .err_clr          (err_clr),
    .xfer_timeout     (xfer_timeout)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic [31:0]   addr;
    logic          wr;
    logic [LW-1:0] len;
    logic [2:0]    size;
    logic          spl;
    logic [7:0]    op;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic push_ahb();
    cmd_t c;
    c.addr = ahb_addr; c.wr = ahb_write; c.len = ahb_len; c.size = ahb_size;
    c.spl = 1'b0; c.op = 8'h00;
    exp_q.push_back(c);
  endtask

  task automatic push_spl();
    cmd_t c;
    c.addr = spl_instr_addr; c.wr = spl_instr_write; c.len = spl_instr_len; c.size = 3'b000;
    c.spl = 1'b1; c.op = spl_instr_opcode;
    exp_q.push_back(c);
  endtask

  // Scoreboard pop: waits (bounded) for the issue handshake, then compares.
  task automatic sb_issue(input string tag, input int max_wait);
    cmd_t e;
    int   waited;
    waited = 0;
    while (!(mc_cmd_valid && mc_cmd_ready) && waited < max_wait) begin
      step();
      waited++;
    end
    n_cmp++;
    if (!(mc_cmd_valid && mc_cmd_ready)) begin
      n_err++;
      $display("FAIL %s issue: mc_cmd_valid=%b mc_cmd_ready=%b, want handshake", tag, mc_cmd_valid, mc_cmd_ready);
    end else if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s issue: got command addr=%h, want none queued", tag, mc_cmd_addr);
    end else begin
      e = exp_q.pop_front();
      if ({mc_cmd_addr, mc_cmd_write, mc_cmd_len, mc_cmd_size, mc_cmd_spl, mc_cmd_opcode} !==
          {e.addr, e.wr, e.len, e.size, e.spl, e.op}) begin
        n_err++;
        $display("FAIL %s payload: got addr=%h wr=%b len=%0d size=%0d spl=%b op=%h, want addr=%h wr=%b len=%0d size=%0d spl=%b op=%h",
                 tag, mc_cmd_addr, mc_cmd_write, mc_cmd_len, mc_cmd_size, mc_cmd_spl, mc_cmd_opcode,
                 e.addr, e.wr, e.len, e.size, e.spl, e.op);
      end
    end
  endtask

  task automatic test_reset();
    mem_rst = 1'b1;
    ahb_cmd_valid = 1'b0; ahb_addr = '0; ahb_write = 1'b0; ahb_len = '0; ahb_size = '0;
    spl_instr_req = 1'b0; spl_instr_opcode = '0; spl_instr_addr = '0; spl_instr_write = 1'b0;
    spl_instr_len = '0; mc_cmd_ready = 1'b0; mc_xfer_done = 1'b0; err_clr = 1'b0;
    step();
    step();
    mem_rst = 1'b0;
    #1;
    n_cmp++;
    if ({mc_cmd_valid, ahb_cmd_ready, spl_instr_ack, spl_instr_stall, xfer_timeout} !== 5'b0) begin
      n_err++;
      $display("FAIL reset ctrl: got valid/ready/ack/stall/to=%b, want 00000",
               {mc_cmd_valid, ahb_cmd_ready, spl_instr_ack, spl_instr_stall, xfer_timeout});
    end
    n_cmp++;
    if ({mc_cmd_addr, mc_cmd_write, mc_cmd_len, mc_cmd_size, mc_cmd_spl, mc_cmd_opcode} !== 55'd0) begin
      n_err++;
      $display("FAIL reset payload: got addr=%h op=%h, want 0", mc_cmd_addr, mc_cmd_opcode);
    end
    step();
    n_cmp++;
    if (mc_cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset idle: got mc_cmd_valid=%b, want 0", mc_cmd_valid);
    end
  endtask

  task automatic test_ahb_only();
    ahb_addr = 32'h0000_1000; ahb_write = 1'b1; ahb_len = 10'd16; ahb_size = 3'd2;
    ahb_cmd_valid = 1'b1; mc_cmd_ready = 1'b1;
    push_ahb();
    #1;
    n_cmp++;
    if (ahb_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ahb_only ready@N: got %b, want 1", ahb_cmd_ready);
    end
    step();
    ahb_cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (ahb_cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ahb_only ready pulse: got %b in ISSUE, want 0", ahb_cmd_ready);
    end
    sb_issue("ahb_only", 0);
    step();
    n_cmp++;
    if (mc_cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ahb_only busy valid: got %b, want 0", mc_cmd_valid);
    end
    repeat (4) step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if ({spl_instr_ack, spl_instr_stall} !== 2'b00) begin
      n_err++;
      $display("FAIL ahb_only ack/stall: got %b, want 00", {spl_instr_ack, spl_instr_stall});
    end
    ahb_addr = 32'h0000_2000; ahb_write = 1'b0; ahb_len = 10'd4; ahb_size = 3'd1;
    ahb_cmd_valid = 1'b1;
    push_ahb();
    #1;
    n_cmp++;
    if (ahb_cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ahb_only done bubble: got ready=%b at done+1, want 0", ahb_cmd_ready);
    end
    step();
    n_cmp++;
    if (ahb_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ahb_only idle at done+2: got ready=%b, want 1", ahb_cmd_ready);
    end
    step();
    ahb_cmd_valid = 1'b0;
    sb_issue("ahb_only2", 0);
    step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    mem_rst = 1'b1;
    step();
    mem_rst = 1'b0;
    ahb_addr = 32'hA000_0040; ahb_write = 1'b0; ahb_len = 10'd8; ahb_size = 3'd3;
    ahb_cmd_valid = 1'b1;
    push_ahb();
    spl_instr_opcode = 8'h05; spl_instr_addr = 32'h00FF_0000; spl_instr_write = 1'b0;
    spl_instr_len = 10'd3; spl_instr_req = 1'b1;
    push_spl();
    mc_cmd_ready = 1'b1;
    #1;
    n_cmp++;
    if (ahb_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sim ahb first: got ready=%b, want 1", ahb_cmd_ready);
    end
    step();
    ahb_cmd_valid = 1'b0;
    #1;
    sb_issue("sim ahb", 0);
    n_cmp++;
    if (spl_instr_stall !== 1'b0) begin
      n_err++;
      $display("FAIL sim stall on ahb: got %b, want 0", spl_instr_stall);
    end
    step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if (spl_instr_ack !== 1'b0) begin
      n_err++;
      $display("FAIL sim ack on ahb: got %b, want 0", spl_instr_ack);
    end
    step();
    n_cmp++;
    if (spl_instr_stall !== 1'b0) begin
      n_err++;
      $display("FAIL sim stall before grant: got %b, want 0", spl_instr_stall);
    end
    step();
    n_cmp++;
    if (spl_instr_stall !== 1'b1) begin
      n_err++;
      $display("FAIL sim stall after grant: got %b, want 1", spl_instr_stall);
    end
    sb_issue("sim spl", 0);
    step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if ({spl_instr_ack, spl_instr_stall} !== 2'b11) begin
      n_err++;
      $display("FAIL sim done ack/stall: got %b, want 11", {spl_instr_ack, spl_instr_stall});
    end
    spl_instr_req = 1'b0;
    step();
    n_cmp++;
    if ({spl_instr_ack, spl_instr_stall} !== 2'b00) begin
      n_err++;
      $display("FAIL sim after done ack/stall: got %b, want 00", {spl_instr_ack, spl_instr_stall});
    end
    step();
    n_cmp++;
    if (mc_cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sim no regrant: got mc_cmd_valid=%b, want 0", mc_cmd_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_spl;
    ahb_addr = 32'h0000_3000; ahb_write = 1'b1; ahb_len = 10'd32; ahb_size = 3'd2;
    ahb_cmd_valid = 1'b1;
    spl_instr_opcode = 8'h9F; spl_instr_addr = 32'h0000_0100; spl_instr_write = 1'b0;
    spl_instr_len = 10'd2; spl_instr_req = 1'b1;
    mc_cmd_ready = 1'b1;
    push_ahb();
    push_spl();
    for (int i = 0; i < 4; i++) begin
      exp_spl = (i % 2 == 1);
      #1;
      n_cmp++;
      if (ahb_cmd_ready !== !exp_spl) begin
        n_err++;
        $display("FAIL b2b grant %0d: got ahb_cmd_ready=%b, want %b", i, ahb_cmd_ready, !exp_spl);
      end
      step();
      sb_issue($sformatf("b2b %0d", i), 0);
      if (i < 2) begin
        if (exp_spl) begin
          push_spl();
        end else begin
          ahb_addr = ahb_addr + 32'h100;
          push_ahb();
        end
      end
      step();
      mc_xfer_done = 1'b1;
      step();
      mc_xfer_done = 1'b0;
      n_cmp++;
      if (spl_instr_ack !== exp_spl) begin
        n_err++;
        $display("FAIL b2b ack %0d: got %b, want %b", i, spl_instr_ack, exp_spl);
      end
      if (i == 3) begin
        ahb_cmd_valid = 1'b0;
        spl_instr_req = 1'b0;
      end
      step();
    end
    step();
    n_cmp++;
    if (mc_cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b drained: got mc_cmd_valid=%b, want 0", mc_cmd_valid);
    end
  endtask

  task automatic test_backpressure();
    cmd_t e;
    spl_instr_opcode = 8'h35; spl_instr_addr = 32'h00AB_CD00; spl_instr_write = 1'b1;
    spl_instr_len = 10'd7; spl_instr_req = 1'b1;
    mc_cmd_ready = 1'b0;
    push_spl();
    e = exp_q[0];
    step();
    for (int c = 0; c < 7; c++) begin
      mc_xfer_done = (c == 2 || c == 5);
      #1;
      n_cmp++;
      if ({mc_cmd_valid, mc_cmd_addr, mc_cmd_write, mc_cmd_len, mc_cmd_size, mc_cmd_spl, mc_cmd_opcode} !==
          {1'b1, e.addr, e.wr, e.len, e.size, e.spl, e.op}) begin
        n_err++;
        $display("FAIL bp hold %0d: got valid=%b addr=%h op=%h, want valid=1 addr=%h op=%h",
                 c, mc_cmd_valid, mc_cmd_addr, mc_cmd_opcode, e.addr, e.op);
      end
      step();
    end
    mc_xfer_done = 1'b1;
    mc_cmd_ready = 1'b1;
    #1;
    sb_issue("bp", 0);
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if ({spl_instr_ack, spl_instr_stall} !== 2'b01) begin
      n_err++;
      $display("FAIL bp done at ready ignored: got ack/stall=%b, want 01", {spl_instr_ack, spl_instr_stall});
    end
    step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if (spl_instr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL bp ack: got %b, want 1", spl_instr_ack);
    end
    spl_instr_req = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    ahb_addr = 32'h0000_4000; ahb_write = 1'b0; ahb_len = 10'd1; ahb_size = 3'd0;
    ahb_cmd_valid = 1'b1; mc_cmd_ready = 1'b1;
    push_ahb();
    step();
    ahb_cmd_valid = 1'b0;
    sb_issue("wd1", 0);
    step();
    for (int j = 1; j <= TO; j++) begin
      n_cmp++;
      if (xfer_timeout !== 1'b0) begin
        n_err++;
        $display("FAIL wd early busy %0d: got xfer_timeout=%b, want 0", j, xfer_timeout);
      end
      step();
    end
    n_cmp++;
    if (xfer_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL wd set: got xfer_timeout=%b after %0d busy cycles, want 1", xfer_timeout, TO);
    end
    ahb_addr = 32'h0000_4100;
    ahb_cmd_valid = 1'b1;
    push_ahb();
    #1;
    n_cmp++;
    if (ahb_cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL wd abort via DONE: got ready=%b, want 0", ahb_cmd_ready);
    end
    step();
    n_cmp++;
    if ({ahb_cmd_ready, xfer_timeout} !== 2'b11) begin
      n_err++;
      $display("FAIL wd idle sticky: got ready/to=%b, want 11", {ahb_cmd_ready, xfer_timeout});
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    ahb_cmd_valid = 1'b0;
    n_cmp++;
    if (xfer_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL wd err_clr: got xfer_timeout=%b, want 0", xfer_timeout);
    end
    sb_issue("wd2", 0);
    step();
    repeat (TO - 1) step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if (xfer_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL wd done at terminal: got xfer_timeout=%b, want 0", xfer_timeout);
    end
    step();
    ahb_addr = 32'h0000_4200;
    ahb_cmd_valid = 1'b1;
    push_ahb();
    step();
    ahb_cmd_valid = 1'b0;
    sb_issue("wd3", 0);
    step();
    err_clr = 1'b1;
    repeat (TO) step();
    n_cmp++;
    if (xfer_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL wd set beats clear: got xfer_timeout=%b, want 1", xfer_timeout);
    end
    step();
    err_clr = 1'b0;
    n_cmp++;
    if (xfer_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL wd clear after: got xfer_timeout=%b, want 0", xfer_timeout);
    end
  endtask

  task automatic test_reset_mid_busy();
    spl_instr_opcode = 8'hC7; spl_instr_addr = 32'h5555_0000; spl_instr_write = 1'b0;
    spl_instr_len = 10'd9; spl_instr_req = 1'b1; mc_cmd_ready = 1'b1;
    push_spl();
    step();
    sb_issue("rst spl", 0);
    step();
    step();
    n_cmp++;
    if (spl_instr_stall !== 1'b1) begin
      n_err++;
      $display("FAIL rst pre stall: got %b, want 1", spl_instr_stall);
    end
    mem_rst = 1'b1;
    step();
    n_cmp++;
    if ({mc_cmd_valid, spl_instr_ack, spl_instr_stall, xfer_timeout} !== 4'b0) begin
      n_err++;
      $display("FAIL rst mid ctrl: got valid/ack/stall/to=%b, want 0000",
               {mc_cmd_valid, spl_instr_ack, spl_instr_stall, xfer_timeout});
    end
    n_cmp++;
    if ({mc_cmd_addr, mc_cmd_write, mc_cmd_len, mc_cmd_size, mc_cmd_spl, mc_cmd_opcode} !== 55'd0) begin
      n_err++;
      $display("FAIL rst mid payload: got addr=%h spl=%b op=%h, want 0", mc_cmd_addr, mc_cmd_spl, mc_cmd_opcode);
    end
    mem_rst = 1'b0;
    push_spl();
    step();
    n_cmp++;
    if (spl_instr_stall !== 1'b1) begin
      n_err++;
      $display("FAIL rst regrant stall: got %b, want 1", spl_instr_stall);
    end
    sb_issue("rst regrant", 0);
    step();
    mc_xfer_done = 1'b1;
    step();
    mc_xfer_done = 1'b0;
    n_cmp++;
    if (spl_instr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL rst regrant ack: got %b, want 1", spl_instr_ack);
    end
    spl_instr_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ahb_only();
    test_simultaneous();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_reset_mid_busy();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global time limit: bench did not complete");
    $fatal(1, "time limit");
  end

endmodule
